// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU issue stage.
//   - ALU op codes driven to the 64-bit ALU
//   - aluop_e: the 2-bit ALUOp class coming from decode
//   - issue_entry_t: one buffered instruction as presented to the ALU
// The entry widths (XLEN, REG_IDX_W) must match the WIDTH/REGW
// parameters of alu_issue_stage.
package alu_pkg;

  localparam int XLEN      = 64;
  localparam int REG_IDX_W = 5;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [1:0] {
    ALUOP_MEM = 2'b00,
    ALUOP_BR  = 2'b01,
    ALUOP_R   = 2'b10,
    ALUOP_I   = 2'b11
  } aluop_e;

  typedef struct packed {
    logic [XLEN-1:0]      a;
    logic [XLEN-1:0]      b;
    logic [3:0]           op;
    logic [REG_IDX_W-1:0] rd;
    logic                 reg_write;
    logic                 illegal;
  } issue_entry_t;

endpackage

// File: rtl/alu_ctrl.sv
// alu_ctrl: combinational translation of ALUOp/funct3/funct7[5] into the
// 4-bit ALU op code.
// Ports:
//   aluop    in  2  ALUOp class from decode
//   funct3   in  3  instruction funct3
//   funct7_5 in  1  instruction bit 30
//   op       out 4  ALU op code (ADD for unsupported combinations)
//   illegal  out 1  unsupported funct combination
// NOR is never produced here.
module alu_ctrl
  import alu_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] op,
  output logic       illegal
);

  always_comb begin
    op      = ALU_ADD;
    illegal = 1'b0;
    case (aluop_e'(aluop))
      ALUOP_MEM: op = ALU_ADD;
      ALUOP_BR:  op = ALU_SUB;
      ALUOP_R: begin
        case (funct3)
          3'b000:  op = funct7_5 ? ALU_SUB : ALU_ADD;
          3'b111:  op = ALU_AND;
          3'b110:  op = ALU_OR;
          default: illegal = 1'b1;
        endcase
      end
      ALUOP_I: begin
        // Immediate forms have no SUB; bit 30 belongs to the immediate.
        case (funct3)
          3'b000:  op = ALU_ADD;
          3'b111:  op = ALU_AND;
          3'b110:  op = ALU_OR;
          default: illegal = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: issue stage in front of the 64-bit ALU.
// Accepts decoded operands over valid/ready, selects operand B, translates
// ALUOp/funct into the ALU op code, and holds results in a main + skid
// slot pair so in_ready is a flop output (no combinational path from
// out_ready back to decode).
// Ports:
//   clk, rst_n           clock (rising), asynchronous active-low reset
//   flush                drop all buffered entries and any concurrent input
//   in_valid/in_ready    decode handshake; in_ready = ~skid_full (registered)
//   in_rs1_val/in_rs2_val/in_imm  operand sources (WIDTH)
//   in_alu_src           1: B = in_imm, 0: B = rs2 value
//   in_aluop/in_funct3/in_funct7_5  op selection
//   in_rd/in_reg_write   destination
//   out_valid/out_ready  ALU-side handshake
//   out_a/out_b/out_op/out_rd  entry presented to the ALU
//   out_reg_write        destination write enable, forced 0 when illegal
//   out_illegal          unsupported funct combination
// Optional: define ALU_ISSUE_FWD_EN to add writeback forwarding ports
//   in_rs1, in_rs2, fwd_valid, fwd_rd, fwd_data. Forwarding is applied only
//   when an instruction is accepted; buffered entries are not patched.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int REGW  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_rs1_val,
  input  logic [WIDTH-1:0] in_rs2_val,
  input  logic [WIDTH-1:0] in_imm,
  input  logic             in_alu_src,
  input  logic [1:0]       in_aluop,
  input  logic [2:0]       in_funct3,
  input  logic             in_funct7_5,
  input  logic [REGW-1:0]  in_rd,
  input  logic             in_reg_write,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [3:0]       out_op,
  output logic [REGW-1:0]  out_rd,
  output logic             out_reg_write,
  output logic             out_illegal
`ifdef ALU_ISSUE_FWD_EN
  ,
  input  logic [REGW-1:0]  in_rs1,
  input  logic [REGW-1:0]  in_rs2,
  input  logic             fwd_valid,
  input  logic [REGW-1:0]  fwd_rd,
  input  logic [WIDTH-1:0] fwd_data
`endif
);

  logic [WIDTH-1:0] opa_p0;
  logic [WIDTH-1:0] rs2v_p0;
  logic [WIDTH-1:0] opb_p0;
  logic [3:0]       op_p0;
  logic             illegal_p0;
  issue_entry_t     new_p0;

  issue_entry_t     main_p1;
  issue_entry_t     skid_p1;
  logic             vld_p1;
  logic             skid_vld_p1;

  logic             accept;
  logic             consume;

  // ---- p0: input decode and operand selection ----
`ifdef ALU_ISSUE_FWD_EN
  logic fwd_a_p0;
  logic fwd_b_p0;
  assign fwd_a_p0 = fwd_valid && (fwd_rd != '0) && (fwd_rd == in_rs1);
  assign fwd_b_p0 = fwd_valid && (fwd_rd != '0) && (fwd_rd == in_rs2);
  assign opa_p0   = fwd_a_p0 ? fwd_data : in_rs1_val;
  assign rs2v_p0  = fwd_b_p0 ? fwd_data : in_rs2_val;
`else
  assign opa_p0   = in_rs1_val;
  assign rs2v_p0  = in_rs2_val;
`endif
  assign opb_p0 = in_alu_src ? in_imm : rs2v_p0;

  alu_ctrl u_alu_ctrl (
    .aluop    (in_aluop),
    .funct3   (in_funct3),
    .funct7_5 (in_funct7_5),
    .op       (op_p0),
    .illegal  (illegal_p0)
  );

  always_comb begin
    new_p0           = '0;
    new_p0.a         = opa_p0;
    new_p0.b         = opb_p0;
    new_p0.op        = op_p0;
    new_p0.rd        = in_rd;
    new_p0.reg_write = in_reg_write & ~illegal_p0;
    new_p0.illegal   = illegal_p0;
  end

  assign accept  = in_valid & ~skid_vld_p1;
  assign consume = vld_p1 & out_ready;

  // ---- p1: main/skid buffer ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
      main_p1     <= '0;
    end else if (flush) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
    end else if (consume) begin
      // With the skid full in_ready is low, so accept cannot coincide here.
      if (skid_vld_p1) begin
        main_p1     <= skid_p1;
        skid_vld_p1 <= 1'b0;
      end else if (accept) begin
        main_p1 <= new_p0;
      end else begin
        vld_p1 <= 1'b0;
      end
    end else if (accept) begin
      if (!vld_p1) begin
        main_p1 <= new_p0;
        vld_p1  <= 1'b1;
      end else begin
        skid_vld_p1 <= 1'b1;
      end
    end
  end

  // Skid payload is only meaningful while skid_vld_p1 is set.
  always_ff @(posedge clk) begin
    if (!flush && accept && vld_p1 && !consume) begin
      skid_p1 <= new_p0;
    end
  end

  assign in_ready      = ~skid_vld_p1;
  assign out_valid     = vld_p1;
  assign out_a         = main_p1.a;
  assign out_b         = main_p1.b;
  assign out_op        = main_p1.op;
  assign out_rd        = main_p1.rd;
  assign out_reg_write = main_p1.reg_write;
  assign out_illegal   = main_p1.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        rw;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_rs1_val, in_rs2_val, in_imm;
  logic        in_alu_src;
  logic [1:0]  in_aluop;
  logic [2:0]  in_funct3;
  logic        in_funct7_5;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_a, out_b;
  logic [3:0]  out_op;
  logic [4:0]  out_rd;
  logic        out_reg_write;
  logic        out_illegal;

  int checks = 0;
  int errors = 0;

  exp_t        q[$];
  logic [63:0] obs[$];

  alu_issue_stage #(.WIDTH(64), .REGW(5)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_rs1_val    (in_rs1_val),
    .in_rs2_val    (in_rs2_val),
    .in_imm        (in_imm),
    .in_alu_src    (in_alu_src),
    .in_aluop      (in_aluop),
    .in_funct3     (in_funct3),
    .in_funct7_5   (in_funct7_5),
    .in_rd         (in_rd),
    .in_reg_write  (in_reg_write),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_a         (out_a),
    .out_b         (out_b),
    .out_op        (out_op),
    .out_rd        (out_rd),
    .out_reg_write (out_reg_write),
    .out_illegal   (out_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference decode written straight from the op table.
  function automatic exp_t predict(input logic [63:0] rs1, input logic [63:0] rs2,
                                   input logic [63:0] imm, input logic src,
                                   input logic [1:0] aluop, input logic [2:0] f3,
                                   input logic f7, input logic [4:0] rd, input logic rw);
    exp_t e;
    e.a   = rs1;
    e.b   = src ? imm : rs2;
    e.rd  = rd;
    e.ill = 1'b0;
    e.op  = 4'b0010;
    if (aluop == 2'b01)                       e.op = 4'b0110;
    else if (aluop == 2'b00)                  e.op = 4'b0010;
    else if (f3 == 3'b111)                    e.op = 4'b0000;
    else if (f3 == 3'b110)                    e.op = 4'b0001;
    else if (f3 == 3'b000 && aluop == 2'b10 && f7) e.op = 4'b0110;
    else if (f3 == 3'b000)                    e.op = 4'b0010;
    else                                      e.ill = 1'b1;
    e.rw = rw && !e.ill;
    return e;
  endfunction

  // Occupancy model: at most two in flight, FIFO order, flush/reset empty it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
    end else if (flush) begin
      q.delete();
    end else begin
      automatic bit can_take = (q.size() < 2);
      automatic bit pop      = (q.size() > 0) && out_ready;
      automatic bit push     = in_valid && can_take;
      if (pop) void'(q.pop_front());
      if (push) q.push_back(predict(in_rs1_val, in_rs2_val, in_imm, in_alu_src,
                                    in_aluop, in_funct3, in_funct7_5, in_rd, in_reg_write));
    end
  end

  always @(negedge clk) begin
    chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
    chk("in_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
    if (out_valid && q.size() > 0) begin
      chk("out_a", out_a, q[0].a);
      chk("out_b", out_b, q[0].b);
      chk("out_op", {60'd0, out_op}, {60'd0, q[0].op});
      chk("out_rd", {59'd0, out_rd}, {59'd0, q[0].rd});
      chk("out_reg_write", {63'd0, out_reg_write}, {63'd0, q[0].rw});
      chk("out_illegal", {63'd0, out_illegal}, {63'd0, q[0].ill});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [63:0] rs1, input logic [63:0] rs2,
                        input logic [63:0] imm, input logic src, input logic [1:0] aluop,
                        input logic [2:0] f3, input logic f7, input logic [4:0] rd,
                        input logic rw);
    in_valid     = v;
    in_rs1_val   = rs1;
    in_rs2_val   = rs2;
    in_imm       = imm;
    in_alu_src   = src;
    in_aluop     = aluop;
    in_funct3    = f3;
    in_funct7_5  = f7;
    in_rd        = rd;
    in_reg_write = rw;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("reset out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset in_ready", {63'd0, in_ready}, 64'd1);
    chk("reset out_illegal", {63'd0, out_illegal}, 64'd0);
    chk("reset out_reg_write", {63'd0, out_reg_write}, 64'd0);
    chk("reset out_a", out_a, 64'd0);
    chk("reset out_op", {60'd0, out_op}, 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // R-type SUB
    out_ready = 1'b1;
    set_in(1, 64'd100, 64'd30, 64'd0, 0, 2'b10, 3'b000, 1, 5'd7, 1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("sub valid", {63'd0, out_valid}, 64'd1);
    chk("sub op", {60'd0, out_op}, 64'h6);
    chk("sub a", out_a, 64'd100);
    chk("sub b", out_b, 64'd30);
    tick();

    // I-type ADD with bit 30 set and all-ones immediate
    set_in(1, 64'd55, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 1, 2'b11, 3'b000, 1, 5'd9, 1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("itype op", {60'd0, out_op}, 64'h2);
    chk("itype b", out_b, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("itype illegal", {63'd0, out_illegal}, 64'd0);
    tick();

    // Illegal R-type funct3
    set_in(1, 64'd1, 64'd2, 64'd0, 0, 2'b10, 3'b001, 0, 5'd3, 1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("illegal op", {60'd0, out_op}, 64'h2);
    chk("illegal flag", {63'd0, out_illegal}, 64'd1);
    chk("illegal reg_write", {63'd0, out_reg_write}, 64'd0);
    tick();

    // Mixed stream with intermittent consumer stalls
    for (int i = 0; i < 12; i++) begin
      logic [1:0] aop;
      logic [2:0] f3;
      aop = 2'(i % 4);
      f3  = (i % 3 == 0) ? 3'b111 : ((i % 3 == 1) ? 3'b110 : 3'b000);
      if (i == 7) f3 = 3'b010;
      out_ready = (i % 3 != 2);
      set_in(1, 64'(i * 1000 + 1), 64'(i * 77 + 5), 64'hF0F0_0000_0000_0000 | 64'(i),
             1'(i % 2), aop, f3, 1'(i % 5 == 0), 5'(i + 1), 1'(i % 4 != 3));
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();

    // Backpressure: three back-to-back, consumer stalled
    out_ready = 1'b0;
    set_in(1, 64'd11, 64'd1, 64'd0, 0, 2'b00, 3'b000, 0, 5'd1, 1);
    tick();
    set_in(1, 64'd22, 64'd2, 64'd0, 0, 2'b01, 3'b000, 0, 5'd2, 1);
    tick();
    set_in(1, 64'd33, 64'd3, 64'd0, 0, 2'b10, 3'b111, 0, 5'd3, 1);
    @(negedge clk);
    chk("bp in_ready low", {63'd0, in_ready}, 64'd0);
    tick();
    @(negedge clk);
    chk("bp held a", out_a, 64'd11);
    chk("bp held valid", {63'd0, out_valid}, 64'd1);
    tick();
    out_ready = 1'b1;
    obs.delete();
    for (int c = 0; c < 8; c++) begin
      bit go;
      @(negedge clk);
      if (out_valid) obs.push_back(out_a);
      go = in_valid && in_ready;
      tick();
      if (go) in_valid = 1'b0;
    end
    chk("bp third accepted", {63'd0, in_valid}, 64'd0);
    chk("bp count", 64'(obs.size()), 64'd3);
    if (obs.size() == 3) begin
      chk("bp order0", obs[0], 64'd11);
      chk("bp order1", obs[1], 64'd22);
      chk("bp order2", obs[2], 64'd33);
    end

    // Flush with both slots full and an input offered
    out_ready = 1'b0;
    set_in(1, 64'h77, 64'd0, 64'd0, 0, 2'b00, 3'b000, 0, 5'd4, 1);
    tick();
    set_in(1, 64'h78, 64'd0, 64'd0, 0, 2'b00, 3'b000, 0, 5'd5, 1);
    tick();
    flush = 1'b1;
    set_in(1, 64'hDEAD, 64'd0, 64'd0, 0, 2'b00, 3'b000, 0, 5'd6, 1);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush2 out_valid", {63'd0, out_valid}, 64'd0);
    chk("flush2 in_ready", {63'd0, in_ready}, 64'd1);

    // Flush with one slot full and an acceptable input offered
    set_in(1, 64'h99, 64'd0, 64'd0, 0, 2'b00, 3'b000, 0, 5'd7, 1);
    tick();
    flush = 1'b1;
    set_in(1, 64'hBEEF, 64'd0, 64'd0, 0, 2'b00, 3'b000, 0, 5'd8, 1);
    tick();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("flush1 out_valid", {63'd0, out_valid}, 64'd0);
    repeat (3) tick();
    @(negedge clk);
    chk("flush1 no ghost", {63'd0, out_valid}, 64'd0);

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    set_in(1, 64'h5, 64'd0, 64'd0, 0, 2'b00, 3'b000, 0, 5'd9, 1);
    tick();
    set_in(1, 64'h6, 64'd0, 64'd0, 0, 2'b00, 3'b000, 0, 5'd10, 1);
    tick();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst out_valid", {63'd0, out_valid}, 64'd0);
    chk("async rst in_ready", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b0;
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    set_in(1, 64'd40, 64'd2, 64'd0, 0, 2'b10, 3'b110, 0, 5'd11, 1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("post rst or op", {60'd0, out_op}, 64'h1);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
